hawk_struct_mem_resp: RTL and testbench

//  AXI4 single-beat, cacheline-granular memory responder. It is the memory side of the

---
 rtl/hawk_struct_mem_resp.sv | 244 ++++++++++++++++++++++++
 tb/tb_hawk_struct_mem_resp.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_struct_mem_resp.sv
// hawk_struct_mem_resp
//   Single-beat AXI4 cacheline memory responder. It holds DEPTH_CL lines of 512 bits,
//   mapped from byte address BASE_ADDR. It is the backing store for Hawk metadata tables
//   and the target that struct/cacheline initiators talk to.
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous reset, active-high
//   r_reqpkt   : read request  (addr, arlen, arvalid, rready)
//   r_resppkt  : read response (arready, rvalid, rdata, rresp)
//   w_reqpkt   : write request (addr, awvalid, wvalid, data, strb)
//   w_resppkt  : write response (awready, wready, bvalid, bresp)
//   err_cnt    : saturating count of SLVERR responses, reads and writes combined

package hacd_pkg;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        rready;
  } axi_rd_reqpkt_t;

  typedef struct packed {
    logic         arready;
    logic         rvalid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
  } axi_rd_resppkt2_t;

  typedef struct packed {
    logic [63:0]  addr;
    logic         awvalid;
    logic         wvalid;
    logic [511:0] data;
    logic [63:0]  strb;
  } axi_wr_reqpkt_t;

  typedef struct packed {
    logic       awready;
    logic       wready;
    logic       bvalid;
    logic [1:0] bresp;
  } axi_wr_resppkt2_t;

endpackage

module hawk_struct_mem_resp
  import hacd_pkg::*;
#(
  parameter int unsigned DEPTH_CL   = 256,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  axi_rd_reqpkt_t   r_reqpkt,
  output axi_rd_resppkt2_t r_resppkt,
  input  axi_wr_reqpkt_t   w_reqpkt,
  output axi_wr_resppkt2_t w_resppkt,
  output logic [15:0]      err_cnt
);

  localparam int unsigned IdxW = $clog2(DEPTH_CL);
  localparam int unsigned CntW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {RIdle, RWait, RResp} rd_state_e;

  // Storage; deliberately not reset.
  logic [511:0] r_mem [DEPTH_CL];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic         r_aw_full, r_w_full;
  logic [63:0]  r_aw_addr;
  logic [511:0] r_w_data;
  logic [63:0]  r_w_strb;
  logic         r_awready, r_wready;
  logic         r_bvalid;
  logic [1:0]   r_bresp;

  logic            w_aw_hs, w_w_hs, w_commit;
  logic            w_aw_full_d, w_w_full_d;
  logic [63:0]     w_aw_off;
  logic            w_aw_in_range;
  logic [IdxW-1:0] w_aw_idx;
  logic            w_wr_err;

  assign w_aw_hs       = w_reqpkt.awvalid & r_awready;
  assign w_w_hs        = w_reqpkt.wvalid & r_wready;
  assign w_commit      = r_aw_full & r_w_full;
  assign w_aw_off      = r_aw_addr - BASE_ADDR;
  assign w_aw_in_range = (r_aw_addr >= BASE_ADDR) && ((w_aw_off >> 6) < 64'(DEPTH_CL));
  assign w_aw_idx      = w_aw_off[6 +: IdxW];
  assign w_wr_err      = w_commit & ~w_aw_in_range;

  // A handshake can only happen while the flag is clear, so set and clear never collide.
  always_comb begin
    w_aw_full_d = w_aw_hs | (r_aw_full & ~w_commit);
    w_w_full_d  = w_w_hs | (r_w_full & ~w_commit);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RespOkay;
    end else begin
      r_aw_full <= w_aw_full_d;
      r_w_full  <= w_w_full_d;
      // Readies are registered so they stay low for the whole reset period.
      r_awready <= ~w_aw_full_d;
      r_wready  <= ~w_w_full_d;
      if (w_aw_hs) r_aw_addr <= w_reqpkt.addr;
      if (w_w_hs) begin
        r_w_data <= w_reqpkt.data;
        r_w_strb <= w_reqpkt.strb;
      end
      // No bready on the packet: the response is a one-cycle pulse.
      r_bvalid <= w_commit;
      if (w_commit) r_bresp <= w_aw_in_range ? RespOkay : RespSlvErr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_commit && w_aw_in_range) begin
      for (int k = 0; k < 64; k++) begin
        if (r_w_strb[k]) r_mem[w_aw_idx][8*k +: 8] <= r_w_data[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_e     r_rd_state;
  logic [CntW-1:0] r_cnt;
  logic          r_arready, r_rvalid;
  logic [511:0]  r_rdata;
  logic [1:0]    r_rresp;

  logic            w_ar_hs;
  logic [63:0]     w_ar_off;
  logic            w_ar_in_range;
  logic [IdxW-1:0] w_ar_idx;
  logic            w_rd_err;

  assign w_ar_off      = r_reqpkt.addr - BASE_ADDR;
  assign w_ar_in_range = (r_reqpkt.addr >= BASE_ADDR) && ((w_ar_off >> 6) < 64'(DEPTH_CL));
  assign w_ar_idx      = w_ar_off[6 +: IdxW];
  assign w_ar_hs       = (r_rd_state == RIdle) & r_arready & r_reqpkt.arvalid;
  // Only single-beat bursts are served; longer ones still get exactly one error beat.
  assign w_rd_err      = w_ar_hs & (~w_ar_in_range | (r_reqpkt.arlen != 8'd0));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_state <= RIdle;
      r_cnt      <= '0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RespOkay;
    end else begin
      case (r_rd_state)
        RIdle: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            // Memory is sampled here, so a same-cycle write commit is not yet visible.
            r_rdata   <= w_rd_err ? '0 : r_mem[w_ar_idx];
            r_rresp   <= w_rd_err ? RespSlvErr : RespOkay;
            r_cnt     <= CntW'(RD_LATENCY - 1);
            if (RD_LATENCY == 1) begin
              r_rd_state <= RResp;
              r_rvalid   <= 1'b1;
            end else begin
              r_rd_state <= RWait;
            end
          end
        end
        RWait: begin
          r_cnt <= r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) begin
            r_rd_state <= RResp;
            r_rvalid   <= 1'b1;
          end
        end
        RResp: begin
          if (r_reqpkt.rready) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= RIdle;
          end
        end
        default: begin
          r_rd_state <= RIdle;
          r_arready  <= 1'b0;
          r_rvalid   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter; a read and a write error in one cycle add two.
  // ---------------------------------------------------------------------------
  logic [15:0] r_err_cnt;
  logic [16:0] w_err_sum;

  assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_rd_err) + 17'(w_wr_err);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_err_cnt <= '0;
    else       r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    r_resppkt         = '0;
    r_resppkt.arready = r_arready;
    r_resppkt.rvalid  = r_rvalid;
    r_resppkt.rdata   = r_rdata;
    r_resppkt.rresp   = r_rresp;
    w_resppkt         = '0;
    w_resppkt.awready = r_awready;
    w_resppkt.wready  = r_wready;
    w_resppkt.bvalid  = r_bvalid;
    w_resppkt.bresp   = r_bresp;
  end

  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_hawk_struct_mem_resp.sv
// Self-checking bench for hawk_struct_mem_resp: directed scenarios plus a random phase,
// with a line-array reference model and response queues checked by a separate monitor.
module tb_hawk_struct_mem_resp;
  import hacd_pkg::*;

  localparam int unsigned Depth = 16;
  localparam logic [63:0] Base  = 64'h1000;
  localparam int unsigned Lat   = 2;

  logic             clk = 1'b0;
  logic             rst_i;
  axi_rd_reqpkt_t   rq;
  axi_rd_resppkt2_t rs;
  axi_wr_reqpkt_t   wq;
  axi_wr_resppkt2_t ws;
  logic [15:0]      err_cnt;

  hawk_struct_mem_resp #(
    .DEPTH_CL  (Depth),
    .BASE_ADDR (Base),
    .RD_LATENCY(Lat)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .r_reqpkt (rq),
    .r_resppkt(rs),
    .w_reqpkt (wq),
    .w_resppkt(ws),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] data;
    logic [1:0]   resp;
  } rexp_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  rexp_t        rd_exp[$];
  logic [1:0]   wr_exp[$];
  logic [511:0] mdl[Depth];
  int           exp_err = 0;
  rexp_t        mon_re;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit addr_ok(input logic [63:0] a);
    return (a >= Base) && (((a - Base) / 64) < 64'(Depth));
  endfunction

  function automatic int line_of(input logic [63:0] a);
    return int'((a - Base) / 64);
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: compares every presented response against the head of its queue.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (rs.rvalid && rq.rready) begin
        if (rd_exp.size() == 0) chk("r_unexpected", 512'(rd_exp.size()), 512'd1);
        else begin
          mon_re = rd_exp.pop_front();
          chk("rdata", rs.rdata, mon_re.data);
          chk("rresp", 512'(rs.rresp), 512'(mon_re.resp));
        end
      end
      if (ws.bvalid) begin
        if (wr_exp.size() == 0) chk("b_unexpected", 512'(wr_exp.size()), 512'd1);
        else chk("bresp", 512'(ws.bresp), 512'(wr_exp.pop_front()));
      end
    end
  end

  // Applies a write to the model, expecting the matching bresp.
  task automatic model_write(input logic [63:0] a, input logic [511:0] d, input logic [63:0] s);
    if (addr_ok(a)) begin
      int ln = line_of(a);
      for (int k = 0; k < 64; k++) if (s[k]) mdl[ln][8*k +: 8] = d[8*k +: 8];
      wr_exp.push_back(2'b00);
    end else begin
      wr_exp.push_back(2'b10);
      exp_err++;
    end
  endtask

  task automatic model_read(input logic [63:0] a, input logic [7:0] len);
    rexp_t e;
    if (!addr_ok(a) || len != 8'd0) begin
      e.data = '0;
      e.resp = 2'b10;
      exp_err++;
    end else begin
      e.data = mdl[line_of(a)];
      e.resp = 2'b00;
    end
    rd_exp.push_back(e);
  endtask

  task automatic wait_b();
    for (int i = 0; i < 30 && wr_exp.size() != 0; i++) tick();
    chk("b_done", 512'(wr_exp.size() == 0), 512'd1);
    wr_exp.delete();
  endtask

  task automatic wait_r(input bit rand_ready);
    for (int i = 0; i < 60 && rd_exp.size() != 0; i++) begin
      rq.rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    rq.rready = 1'b0;
    chk("r_done", 512'(rd_exp.size() == 0), 512'd1);
    rd_exp.delete();
  endtask

  task automatic do_write(input logic [63:0] a, input logic [511:0] d, input logic [63:0] s,
                          input int aw_dly, input int w_dly);
    bit aw_pend = 1'b1;
    bit w_pend  = 1'b1;
    bit aw_go, w_go;
    model_write(a, d, s);
    wq.addr = a;
    wq.data = d;
    wq.strb = s;
    for (int i = 0; i < 30 && (aw_pend || w_pend); i++) begin
      wq.awvalid = aw_pend && (i >= aw_dly);
      wq.wvalid  = w_pend && (i >= w_dly);
      aw_go = wq.awvalid && ws.awready;
      w_go  = wq.wvalid && ws.wready;
      tick();
      if (aw_go) aw_pend = 1'b0;
      if (w_go) w_pend = 1'b0;
    end
    wq.awvalid = 1'b0;
    wq.wvalid  = 1'b0;
    chk("aw_w_accepted", 512'(aw_pend || w_pend), 512'd0);
    wait_b();
  endtask

  task automatic do_read(input logic [63:0] a, input logic [7:0] len);
    bit go;
    model_read(a, len);
    rq.addr    = a;
    rq.arlen   = len;
    rq.arvalid = 1'b1;
    for (int i = 0; i < 20 && rq.arvalid; i++) begin
      go = rs.arready;
      tick();
      if (go) rq.arvalid = 1'b0;
    end
    chk("ar_accepted", 512'(rq.arvalid), 512'd0);
    rq.arvalid = 1'b0;
    wait_r(1'b1);
  endtask

  task automatic chk_readies(input string name, input logic v);
    chk({name, "_arready"}, 512'(rs.arready), 512'(v));
    chk({name, "_awready"}, 512'(ws.awready), 512'(v));
    chk({name, "_wready"}, 512'(ws.wready), 512'(v));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] x, y, z;
    logic [63:0]  a;
    logic [7:0]   len;
    logic [63:0]  s;
    rexp_t        e;

    rst_i = 1'b1;
    rq    = '0;
    wq    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_readies("rst", 1'b0);
    chk("rst_rvalid", 512'(rs.rvalid), 512'd0);
    chk("rst_bvalid", 512'(ws.bvalid), 512'd0);
    chk("rst_rdata", rs.rdata, 512'd0);
    chk("rst_rresp", 512'(rs.rresp), 512'd0);
    chk("rst_bresp", 512'(ws.bresp), 512'd0);
    chk("rst_err_cnt", 512'(err_cnt), 512'd0);
    rst_i = 1'b0;
    tick();
    chk_readies("post_rst", 1'b1);

    for (int ln = 0; ln < Depth; ln++) do_write(Base + 64'(ln) * 64, rand512(), '1, 0, 0);

    // 1: W first, AW three cycles later
    x = {64{8'hA5}};
    model_write(Base + 64'h40, x, '1);
    wq.data   = x;
    wq.strb   = '1;
    wq.wvalid = 1'b1;
    chk("t1_wready_c0", 512'(ws.wready), 512'd1);
    tick();
    wq.wvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("t1_wready_low", 512'(ws.wready), 512'd0);
      if (c == 3) begin
        chk("t1_awready_c3", 512'(ws.awready), 512'd1);
        wq.addr    = Base + 64'h40;
        wq.awvalid = 1'b1;
      end
      tick();
    end
    wq.awvalid = 1'b0;
    chk("t1_bvalid_c4", 512'(ws.bvalid), 512'd0);
    tick();
    chk("t1_bvalid_c5", 512'(ws.bvalid), 512'd1);
    chk("t1_bresp_c5", 512'(ws.bresp), 512'd0);
    chk("t1_awready_c5", 512'(ws.awready), 512'd1);
    chk("t1_wready_c5", 512'(ws.wready), 512'd1);
    tick();
    chk("t1_bvalid_pulse", 512'(ws.bvalid), 512'd0);
    wait_b();
    do_read(Base + 64'h40, 8'd0);

    // 2: partial strobe on a zeroed line
    do_write(Base + 3 * 64, '0, '1, 1, 0);
    y = rand512();
    y[7:0] = 8'h5C;
    do_write(Base + 3 * 64, y, 64'h1, 0, 2);
    do_read(Base + 3 * 64, 8'd0);

    // 3: latency and stall stability
    e.data = mdl[3];
    e.resp = 2'b00;
    rd_exp.push_back(e);
    rq.addr    = Base + 3 * 64;
    rq.arlen   = 8'd0;
    rq.rready  = 1'b0;
    chk("t3_arready_c0", 512'(rs.arready), 512'd1);
    rq.arvalid = 1'b1;
    tick();
    rq.arvalid = 1'b0;
    chk("t3_rvalid_c1", 512'(rs.rvalid), 512'd0);
    chk("t3_arready_c1", 512'(rs.arready), 512'd0);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("t3_rvalid_hold", 512'(rs.rvalid), 512'd1);
      chk("t3_rdata_hold", rs.rdata, e.data);
      chk("t3_arready_hold", 512'(rs.arready), 512'd0);
      tick();
    end
    rq.rready = 1'b1;
    tick();
    rq.rready = 1'b0;
    chk("t3_rvalid_done", 512'(rs.rvalid), 512'd0);
    chk("t3_arready_back", 512'(rs.arready), 512'd1);
    chk("t3_popped", 512'(rd_exp.size()), 512'd0);

    // 4: error responses
    chk("t4_err_cnt_before", 512'(err_cnt), 512'd0);
    do_read(Base + 64'(Depth) * 64, 8'd0);
    do_read(Base + 5 * 64, 8'd1);
    do_write(Base + 64'(Depth) * 64 + 64'h80, rand512(), '1, 0, 0);
    chk("t4_err_cnt", 512'(err_cnt), 512'd3);

    // 5: read accept and write commit to the same line in the same cycle
    x = rand512();
    do_write(Base + 7 * 64, x, '1, 0, 0);
    y = rand512();
    wq.addr    = Base + 7 * 64;
    wq.data    = y;
    wq.strb    = '1;
    wq.awvalid = 1'b1;
    wq.wvalid  = 1'b1;
    chk("t5_wr_ready", 512'(ws.awready && ws.wready), 512'd1);
    tick();
    wq.awvalid = 1'b0;
    wq.wvalid  = 1'b0;
    wr_exp.push_back(2'b00);
    e.data = x;
    e.resp = 2'b00;
    rd_exp.push_back(e);
    rq.addr    = Base + 7 * 64;
    rq.arlen   = 8'd0;
    rq.arvalid = 1'b1;
    chk("t5_arready", 512'(rs.arready), 512'd1);
    tick();
    rq.arvalid = 1'b0;
    mdl[7] = y;
    wait_r(1'b0);
    wait_b();
    do_read(Base + 7 * 64, 8'd0);

    // Random phase, serialized so the model order is the issue order
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = ($urandom_range(0, 1) == 1) ? Base + 64'($urandom_range(Depth, Depth + 7)) * 64
                                         : Base - 64'($urandom_range(1, 4)) * 64;
      end else begin
        a = Base + 64'($urandom_range(0, Depth - 1)) * 64;
      end
      a[5:0] = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        do_read(a, len);
      end else begin
        s = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
        do_write(a, rand512(), s, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end
    chk("rand_err_cnt", 512'(err_cnt), 512'(exp_err));

    // 6: reset with a read in R_WAIT and a lone AW held
    rq.addr    = Base + 2 * 64;
    rq.arlen   = 8'd0;
    rq.arvalid = 1'b1;
    wq.addr    = Base + 4 * 64;
    wq.awvalid = 1'b1;
    tick();
    rq.arvalid = 1'b0;
    wq.awvalid = 1'b0;
    chk("t6_awready_full", 512'(ws.awready), 512'd0);
    chk("t6_in_wait", 512'(rs.rvalid), 512'd0);
    rst_i = 1'b1;
    #1;
    chk_readies("t6_rst", 1'b0);
    chk("t6_rst_err_cnt", 512'(err_cnt), 512'd0);
    tick();
    tick();
    chk_readies("t6_rst_held", 1'b0);
    chk("t6_rst_rvalid", 512'(rs.rvalid), 512'd0);
    rst_i   = 1'b0;
    exp_err = 0;
    tick();
    chk_readies("t6_release", 1'b1);
    for (int c = 0; c < 8; c++) begin
      chk("t6_no_rvalid", 512'(rs.rvalid), 512'd0);
      chk("t6_no_bvalid", 512'(ws.bvalid), 512'd0);
      tick();
    end
    // The dropped AW must not pair with a fresh W.
    z = rand512();
    wq.data   = z;
    wq.strb   = '1;
    wq.wvalid = 1'b1;
    tick();
    wq.wvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t6_w_only_no_bvalid", 512'(ws.bvalid), 512'd0);
      tick();
    end
    model_write(Base + 4 * 64, z, '1);
    wq.addr    = Base + 4 * 64;
    wq.awvalid = 1'b1;
    tick();
    wq.awvalid = 1'b0;
    wait_b();

    for (int ln = 0; ln < Depth; ln++) do_read(Base + 64'(ln) * 64, 8'd0);
    chk("final_err_cnt", 512'(err_cnt), 512'(exp_err));

    repeat (3) tick();
    chk("final_rd_queue", 512'(rd_exp.size()), 512'd0);
    chk("final_wr_queue", 512'(wr_exp.size()), 512'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
